// File: rtl/core_pkg.sv
// Shared core parameters: default widths, register address width and lane index type.
package core_pkg;

   localparam int unsigned XLEN_DEF  = 32;
   localparam int unsigned NREG_DEF  = 32;
   localparam int unsigned LANES_DEF = 2;
   localparam int unsigned AW_DEF    = $clog2(NREG_DEF);

   // Wide enough for the maximum of four lanes.
   typedef logic [1:0] lane_idx_t;

   function automatic int unsigned reg_aw(input int unsigned nreg);
      return $clog2(nreg);
   endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Issue / writeback / read bundle between the pipeline and the register file scoreboard.
interface regfile_scoreboard_if #(
   parameter int unsigned XLEN  = core_pkg::XLEN_DEF,
   parameter int unsigned NREG  = core_pkg::NREG_DEF,
   parameter int unsigned LANES = core_pkg::LANES_DEF
);

   localparam int unsigned AW = core_pkg::reg_aw(NREG);

   logic                    flush;
   logic [LANES*AW-1:0]     rs1_addr;
   logic [LANES*AW-1:0]     rs2_addr;
   logic [LANES*XLEN-1:0]   rs1_data;
   logic [LANES*XLEN-1:0]   rs2_data;
   logic [LANES-1:0]        rs1_rdy;
   logic [LANES-1:0]        rs2_rdy;
   logic [LANES-1:0]        iss_valid;
   logic [LANES*AW-1:0]     iss_rd;
   logic [LANES-1:0]        iss_ok;
   logic [LANES-1:0]        wb_valid;
   logic [LANES*AW-1:0]     wb_rd;
   logic [LANES*XLEN-1:0]   wb_data;
   logic                    wb_swap;
   logic [NREG-1:0]         busy_vec;

   modport master (
      output flush, rs1_addr, rs2_addr, iss_valid, iss_rd,
             wb_valid, wb_rd, wb_data, wb_swap,
      input  rs1_data, rs2_data, rs1_rdy, rs2_rdy, iss_ok, busy_vec
   );

   modport slave (
      input  flush, rs1_addr, rs2_addr, iss_valid, iss_rd,
             wb_valid, wb_rd, wb_data, wb_swap,
      output rs1_data, rs2_data, rs1_rdy, rs2_rdy, iss_ok, busy_vec
   );

endinterface

// File: rtl/rf_bypass_mux.sv
// One read port: stored value, or the youngest same-cycle writeback to the same nonzero address.
module rf_bypass_mux #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned AW    = 5,
   parameter int unsigned LANES = 2
) (
   input  logic [AW-1:0]         addr,
   input  logic [XLEN-1:0]       stored,
   input  logic [LANES-1:0]      wb_valid,
   input  logic [LANES*AW-1:0]   wb_rd,
   input  logic [LANES*XLEN-1:0] wb_data,
   input  logic                  wb_swap,
   output logic [XLEN-1:0]       data
);

   always_comb begin
      int unsigned l;
      data = stored;
      // Scan oldest to youngest so the last hit is the youngest lane.
      for (int unsigned k = 0; k < LANES; k++) begin
         l = wb_swap ? (LANES - 1 - k) : k;
         if (wb_valid[l] && (wb_rd[l*AW +: AW] == addr))
            data = wb_data[l*XLEN +: XLEN];
      end
      if (addr == '0)
         data = '0;
   end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-lane register file with busy-bit scoreboard, in-order issue check and writeback bypass.
module regfile_scoreboard
   import core_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEF,
   parameter int unsigned NREG  = NREG_DEF,
   parameter int unsigned LANES = LANES_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   regfile_scoreboard_if.slave  bus
);

   localparam int unsigned AW = reg_aw(NREG);

   logic [XLEN-1:0]  regs [NREG];
   logic [NREG-1:0]  busy;
   logic [NREG-1:0]  busy_clr;
   logic [NREG-1:0]  busy_set;
   logic [LANES-1:0] ok;
   logic [XLEN-1:0]  rd1 [LANES];
   logic [XLEN-1:0]  rd2 [LANES];

   always_comb begin
      busy_clr = '0;
      for (int unsigned l = 0; l < LANES; l++)
         if (bus.wb_valid[l])
            busy_clr[bus.wb_rd[l*AW +: AW]] = 1'b1;
   end

   always_comb begin
      logic          older_ok;
      logic          blocked;
      logic [AW-1:0] rd;
      logic [AW-1:0] rd_i;
      ok       = '0;
      older_ok = 1'b1;
      for (int unsigned l = 0; l < LANES; l++) begin
         rd      = bus.iss_rd[l*AW +: AW];
         blocked = busy[rd] & ~busy_clr[rd];
         for (int unsigned i = 0; i < l; i++) begin
            rd_i = bus.iss_rd[i*AW +: AW];
            if (bus.iss_valid[i] && (rd_i == rd) && (rd_i != '0))
               blocked = 1'b1;
         end
         ok[l]    = ~blocked & older_ok;
         older_ok = ok[l];
      end
   end

   always_comb begin
      logic [AW-1:0] rd;
      busy_set = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         rd = bus.iss_rd[l*AW +: AW];
         if (bus.iss_valid[l] && ok[l] && (rd != '0))
            busy_set[rd] = 1'b1;
      end
   end

   // Set wins over clear: the issuing instruction is younger than the writeback.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         busy <= '0;
      else if (bus.flush)
         busy <= '0;
      else
         busy <= (busy & ~busy_clr) | busy_set;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned r = 0; r < NREG; r++)
            regs[r] <= '0;
      end else begin
         int unsigned   l;
         logic [AW-1:0] rd;
         for (int unsigned k = 0; k < LANES; k++) begin
            l  = bus.wb_swap ? (LANES - 1 - k) : k;
            rd = bus.wb_rd[l*AW +: AW];
            if (bus.wb_valid[l] && (rd != '0))
               regs[rd] <= bus.wb_data[l*XLEN +: XLEN];
         end
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_rd
      rf_bypass_mux #(.XLEN(XLEN), .AW(AW), .LANES(LANES)) u_mux1 (
         .addr     (bus.rs1_addr[g*AW +: AW]),
         .stored   (regs[bus.rs1_addr[g*AW +: AW]]),
         .wb_valid (bus.wb_valid),
         .wb_rd    (bus.wb_rd),
         .wb_data  (bus.wb_data),
         .wb_swap  (bus.wb_swap),
         .data     (rd1[g])
      );
      rf_bypass_mux #(.XLEN(XLEN), .AW(AW), .LANES(LANES)) u_mux2 (
         .addr     (bus.rs2_addr[g*AW +: AW]),
         .stored   (regs[bus.rs2_addr[g*AW +: AW]]),
         .wb_valid (bus.wb_valid),
         .wb_rd    (bus.wb_rd),
         .wb_data  (bus.wb_data),
         .wb_swap  (bus.wb_swap),
         .data     (rd2[g])
      );
   end

   always_comb begin
      logic [AW-1:0] a1;
      logic [AW-1:0] a2;
      logic [AW-1:0] rd_i;
      bus.rs1_data = '0;
      bus.rs2_data = '0;
      bus.rs1_rdy  = '0;
      bus.rs2_rdy  = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         a1 = bus.rs1_addr[l*AW +: AW];
         a2 = bus.rs2_addr[l*AW +: AW];
         bus.rs1_data[l*XLEN +: XLEN] = rd1[l];
         bus.rs2_data[l*XLEN +: XLEN] = rd2[l];
         bus.rs1_rdy[l] = (a1 == '0) | ~busy[a1] | busy_clr[a1];
         bus.rs2_rdy[l] = (a2 == '0) | ~busy[a2] | busy_clr[a2];
         // An older lane issuing to this source in the same bundle is a RAW hazard.
         for (int unsigned i = 0; i < l; i++) begin
            rd_i = bus.iss_rd[i*AW +: AW];
            if (bus.iss_valid[i] && ok[i] && (rd_i == a1) && (a1 != '0))
               bus.rs1_rdy[l] = 1'b0;
            if (bus.iss_valid[i] && ok[i] && (rd_i == a2) && (a2 != '0))
               bus.rs2_rdy[l] = 1'b0;
         end
      end
   end

   assign bus.iss_ok   = ok;
   assign bus.busy_vec = busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed checks of regfile_scoreboard with two lanes, 32 registers, 32-bit data.
module tb_regfile_scoreboard;

   logic clk;
   logic reset;
   int   n_total = 0;
   int   n_bad   = 0;

   regfile_scoreboard_if #(.XLEN(32), .NREG(32), .LANES(2)) bus ();

   regfile_scoreboard #(.XLEN(32), .NREG(32), .LANES(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      bus.flush     = 1'b0;
      bus.rs1_addr  = '0;
      bus.rs2_addr  = '0;
      bus.iss_valid = '0;
      bus.iss_rd    = '0;
      bus.wb_valid  = '0;
      bus.wb_rd     = '0;
      bus.wb_data   = '0;
      bus.wb_swap   = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      reset = 1'b0;
      idle();
      #1;
      chk("rst_busy", bus.busy_vec, 0);
      bus.rs1_addr = {5'd5, 5'd7};
      #1;
      chk("rst_rd", bus.rs1_data, 0);
      chk("rst_rdy", bus.rs1_rdy, 2'b11);
      bus.iss_valid = 2'b11;
      bus.iss_rd    = {5'd3, 5'd3};
      #1;
      chk("rst_issok", bus.iss_ok, 2'b01);

      idle();
      bus.wb_valid = 2'b01;
      bus.wb_rd    = {5'd0, 5'd13};
      bus.wb_data  = {32'h0, 32'h5555};
      step();
      step();
      idle();
      reset = 1'b1;
      bus.rs1_addr = {5'd0, 5'd13};
      #1;
      chk("rst_nowrite", bus.rs1_data[31:0], 0);
      chk("rst_nobusy", bus.busy_vec, 0);

      // same-address writeback, lane order normal then swapped
      idle();
      bus.wb_valid = 2'b11;
      bus.wb_rd    = {5'd5, 5'd5};
      bus.wb_data  = {32'hBBBB, 32'hAAAA};
      bus.rs1_addr = {5'd0, 5'd5};
      #1;
      chk("byp_swap0", bus.rs1_data[31:0], 32'hBBBB);
      step();
      idle();
      bus.rs2_addr = {5'd5, 5'd0};
      #1;
      chk("wb_swap0", bus.rs2_data[63:32], 32'hBBBB);
      chk("x0_read", bus.rs2_data[31:0], 0);
      bus.wb_swap  = 1'b1;
      bus.wb_valid = 2'b11;
      bus.wb_rd    = {5'd5, 5'd5};
      bus.wb_data  = {32'hBBBB, 32'hAAAA};
      bus.rs1_addr = {5'd0, 5'd5};
      #1;
      chk("byp_swap1", bus.rs1_data[31:0], 32'hAAAA);
      step();
      idle();
      bus.rs1_addr = {5'd0, 5'd5};
      #1;
      chk("wb_swap1", bus.rs1_data[31:0], 32'hAAAA);

      // issue x7, then writeback x7
      idle();
      bus.iss_valid = 2'b01;
      bus.iss_rd    = {5'd0, 5'd7};
      #1;
      chk("iss_x7_ok", bus.iss_ok, 2'b11);
      step();
      idle();
      bus.rs1_addr = {5'd0, 5'd7};
      bus.iss_rd   = {5'd0, 5'd7};
      #1;
      chk("busy_x7", bus.busy_vec[7], 1);
      chk("rdy_x7_busy", bus.rs1_rdy[0], 0);
      chk("waw_x7", bus.iss_ok, 2'b00);
      bus.wb_valid = 2'b01;
      bus.wb_rd    = {5'd0, 5'd7};
      bus.wb_data  = {32'h0, 32'h1234};
      #1;
      chk("rdy_x7_wb", bus.rs1_rdy[0], 1);
      chk("byp_x7", bus.rs1_data[31:0], 32'h1234);
      chk("iss_x7_wb", bus.iss_ok, 2'b11);
      step();
      idle();
      bus.rs1_addr = {5'd0, 5'd7};
      #1;
      chk("busy_x7_clr", bus.busy_vec[7], 0);
      chk("rd_x7", bus.rs1_data[31:0], 32'h1234);

      // intra-bundle WAW and RAW on x3
      idle();
      bus.iss_valid = 2'b11;
      bus.iss_rd    = {5'd3, 5'd3};
      bus.rs1_addr  = {5'd3, 5'd3};
      #1;
      chk("waw_bundle", bus.iss_ok, 2'b01);
      chk("raw_bundle", bus.rs1_rdy, 2'b01);
      bus.iss_valid = 2'b00;
      #1;
      chk("raw_noiss", bus.rs1_rdy, 2'b11);

      // writeback and new issue to x9 in the same cycle
      idle();
      bus.iss_valid = 2'b01;
      bus.iss_rd    = {5'd0, 5'd9};
      step();
      idle();
      #1;
      chk("busy_x9", bus.busy_vec[9], 1);
      bus.wb_valid  = 2'b01;
      bus.wb_rd     = {5'd0, 5'd9};
      bus.wb_data   = {32'h0, 32'h9999};
      bus.iss_valid = 2'b01;
      bus.iss_rd    = {5'd0, 5'd9};
      #1;
      chk("iss_x9_wb", bus.iss_ok[0], 1);
      step();
      idle();
      bus.rs1_addr = {5'd0, 5'd9};
      #1;
      chk("busy_x9_set", bus.busy_vec[9], 1);
      chk("rd_x9", bus.rs1_data[31:0], 32'h9999);
      chk("rdy_x9", bus.rs1_rdy[0], 0);

      // flush, and writes to x0
      idle();
      bus.iss_valid = 2'b11;
      bus.iss_rd    = {5'd2, 5'd1};
      step();
      bus.iss_rd    = {5'd4, 5'd3};
      step();
      idle();
      #1;
      chk("busy_pre_flush", bus.busy_vec, 32'h0000_021E);
      bus.flush     = 1'b1;
      bus.iss_valid = 2'b01;
      bus.iss_rd    = {5'd0, 5'd10};
      bus.wb_valid  = 2'b01;
      bus.wb_rd     = {5'd0, 5'd11};
      bus.wb_data   = {32'h0, 32'h1111};
      step();
      idle();
      bus.rs1_addr = {5'd0, 5'd11};
      #1;
      chk("busy_flush", bus.busy_vec, 0);
      chk("rd_x11_flush", bus.rs1_data[31:0], 32'h1111);
      bus.wb_valid  = 2'b01;
      bus.wb_rd     = {5'd0, 5'd0};
      bus.wb_data   = {32'h0, 32'hFFFF};
      bus.iss_valid = 2'b01;
      bus.iss_rd    = {5'd0, 5'd0};
      bus.rs1_addr  = {5'd0, 5'd0};
      #1;
      chk("byp_x0", bus.rs1_data[31:0], 0);
      chk("rdy_x0", bus.rs1_rdy[0], 1);
      step();
      idle();
      #1;
      chk("rd_x0", bus.rs1_data[31:0], 0);
      chk("busy_x0", bus.busy_vec, 0);

      // asynchronous reset mid-cycle
      bus.iss_valid = 2'b01;
      bus.iss_rd    = {5'd0, 5'd12};
      step();
      idle();
      bus.rs1_addr = {5'd7, 5'd5};
      #1;
      chk("busy_x12", bus.busy_vec[12], 1);
      chk("pre_rst_x5", bus.rs1_data[31:0], 32'hAAAA);
      #3;
      reset = 1'b0;
      #1;
      chk("arst_busy", bus.busy_vec, 0);
      chk("arst_regs", bus.rs1_data, 0);
      chk("arst_rdy", bus.rs1_rdy, 2'b11);
      #2;
      reset = 1'b1;
      step();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
